// File: rtl/change_evt_pkg.sv
// rtl/change_evt_pkg.sv - shared widths and helpers for the change event FIFO
package change_evt_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_TS_WIDTH   = 16;
    localparam int DEF_DROP_WIDTH = 8;

    // Occupancy needs one more bit than the pointers so that DEPTH itself fits.
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // All-ones value of a saturating counter of the given width (width < 64).
    function automatic logic [63:0] drop_sat_max(input int width);
        return (64'(1) << width) - 64'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous show-ahead FIFO
//   clk, rst          : clock, synchronous active-high reset
//   push, wdata       : write strobe and data (ignored when full unless popping)
//   pop               : read strobe (ignored when empty)
//   rdata             : head entry, valid whenever !empty
//   count, full, empty: occupancy status
module sync_fifo
    import change_evt_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wdata,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rdata,
    output logic [clog2_cnt(DEPTH)-1:0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = clog2_cnt(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/change_event_fifo.sv
// rtl/change_event_fifo.sv - captures sig on each change pulse into a show-ahead event FIFO
//   Optional macro CHANGE_EVT_TIMESTAMP_EN: stores a free-running timestamp with each entry.
//   clk, rst                  : clock, synchronous active-high reset
//   pulse, sig                : change strobe and value to capture
//   evt_valid/evt_ready       : head entry handshake
//   evt_value, evt_ts         : head entry value and timestamp ('0 without the macro)
//   evt_count, full           : occupancy status
//   overflow, drop_cnt        : sticky drop flag and saturating drop counter
//   clr_overflow              : clears overflow and drop_cnt
module change_event_fifo
    import change_evt_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pulse,
    input  logic [WIDTH-1:0]              sig,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [WIDTH-1:0]              evt_value,
    output logic [TS_WIDTH-1:0]           evt_ts,
    output logic [clog2_cnt(DEPTH)-1:0]   evt_count,
    output logic                          full,
    output logic                          overflow,
    output logic [DROP_WIDTH-1:0]         drop_cnt,
    input  logic                          clr_overflow
);

    localparam logic [DROP_WIDTH-1:0] DROP_MAX = DROP_WIDTH'(drop_sat_max(DROP_WIDTH));

`ifdef CHANGE_EVT_TIMESTAMP_EN
    localparam int ENTRY_W = WIDTH + TS_WIDTH;
`else
    localparam int ENTRY_W = WIDTH;
`endif

    logic               empty;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign drop      = pulse && full && !pop;

`ifdef CHANGE_EVT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign wr_entry  = {sig, ts};
    assign evt_value = rd_entry[ENTRY_W-1 -: WIDTH];
    assign evt_ts    = rd_entry[TS_WIDTH-1:0];
`else
    assign wr_entry  = sig;
    assign evt_value = rd_entry;
    assign evt_ts    = '0;
`endif

    // The FIFO applies the full/pop acceptance rule itself; a refused push is a drop.
    sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pulse),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .count (evt_count),
        .full  (full),
        .empty (empty)
    );

    // A clear in the same cycle as a drop wipes history first, then counts the new drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_overflow) begin
            overflow <= drop;
            drop_cnt <= drop ? DROP_WIDTH'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_change_event_fifo.sv
// tb/tb_change_event_fifo.sv - scoreboard bench for change_event_fifo
module tb_change_event_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse;
    logic [31:0] sig;
    logic        evt_valid;
    logic        evt_ready;
    logic [31:0] evt_value;
    logic [15:0] evt_ts;
    logic [3:0]  evt_count;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_overflow;

    always #5 clk = ~clk;

    change_event_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .pulse        (pulse),
        .sig          (sig),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_value    (evt_value),
        .evt_ts       (evt_ts),
        .evt_count    (evt_count),
        .full         (full),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_overflow (clr_overflow)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [47:0] exp_q[$];
    logic [15:0] tb_ts;
    logic        m_ovf;
    logic [7:0]  m_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        chk("evt_valid", 64'(evt_valid), 64'(exp_q.size() != 0));
        chk("evt_count", 64'(evt_count), 64'(exp_q.size()));
        chk("full",      64'(full),      64'(exp_q.size() == 8));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    endtask

    // Called on a negedge: drive inputs, predict, cross one posedge, check on the next negedge.
    task automatic step(input logic p, input logic [31:0] s, input logic r, input logic c);
        int          sz;
        logic        m_pop;
        logic        m_drp;
        logic [47:0] head;
        pulse        = p;
        sig          = s;
        evt_ready    = r;
        clr_overflow = c;
        #1;
        sz    = exp_q.size();
        m_pop = r && (sz != 0);
        m_drp = p && (sz == 8) && !m_pop;
        if (m_pop) begin
            head = exp_q.pop_front();
            chk("evt_value", 64'(evt_value), 64'(head[47:16]));
            chk("evt_ts",    64'(evt_ts),    64'(head[15:0]));
        end
        if (p && !m_drp) begin
`ifdef CHANGE_EVT_TIMESTAMP_EN
            exp_q.push_back({s, tb_ts});
`else
            exp_q.push_back({s, 16'h0});
`endif
        end
        if (c) begin
            m_ovf  = m_drp;
            m_drop = m_drp ? 8'd1 : 8'd0;
        end else if (m_drp) begin
            m_ovf = 1'b1;
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
        @(posedge clk);
        tb_ts = tb_ts + 16'd1;
        @(negedge clk);
        chk_status();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        pulse        = 1'b0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        sig          = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tb_ts  = 16'd0;
        m_ovf  = 1'b0;
        m_drop = 8'd0;
        chk_status();
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // First capture after five idle cycles, then drain it.
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        // Ready while empty is ignored.
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill with 1..8, drop three, drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h1FF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Empty with pulse and ready together: push only.
        step(1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Drop counter saturation, clear with drop, clear alone.
        for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, 32'($urandom), 1'b0, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Reset mid-operation with four queued entries.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
        do_reset();
        step(1'b1, 32'h500, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
